// File: rtl/flash_pkg.sv
// ---------------------------------------------------------------------------
// flash_pkg
// Shared definitions for the 6809-side flash read sequencer:
//   - state_e          : sequencer FSM states
//   - FLASH_READ_CMD   : SPI read opcode the downstream controller issues
//   - FLASH_BLANK_BYTE : byte presented on an aborted read (erased-flash value)
//   - spi_read_frame() : opcode/pad/address frame for one read, for the
//                        controller side and for models
// ---------------------------------------------------------------------------
package flash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    BUSY,
    CAPTURE,
    DONE
  } state_e;

  localparam logic [7:0] FLASH_READ_CMD   = 8'h03;
  localparam logic [7:0] FLASH_BLANK_BYTE = 8'hFF;

  // Frame the SPI controller shifts out for a read of the 16-bit CPU address:
  // opcode, a zero upper address byte, then the address.
  function automatic logic [31:0] spi_read_frame(input logic [15:0] addr);
    return {FLASH_READ_CMD, 8'h00, addr};
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous level into the clk domain through a STAGES-deep flop
// chain and derives single-cycle edge pulses from the synchronised level.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset (all flops clear to 0)
//   i_async  in   asynchronous input level
//   o_level  out  synchronised level
//   o_rise   out  one-cycle pulse on a synchronised 0->1 transition
//   o_fall   out  one-cycle pulse on a synchronised 1->0 transition
// STAGES must be at least 2.
// ---------------------------------------------------------------------------
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], i_async};
    prev_d = sync_q[STAGES-1];
  end

  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge value of the others; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_level = sync_q[STAGES-1];
  assign o_rise  = sync_q[STAGES-1] & ~prev_q;
  assign o_fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/flash_read_sequencer.sv
// ---------------------------------------------------------------------------
// flash_read_sequencer
// Sits between the 6809 bus and the SPI flash controller. A read of the flash
// window stretches the CPU (MRDY low), requests the byte from the controller
// with a CE/READY handshake, and drives the returned byte onto the data bus
// until E falls. A one-entry last-address cache satisfies a repeated read
// without touching SPI. A stuck controller is abandoned after TIMEOUT_CYCLES.
// Ports:
//   clk             in   system clock
//   i_RST_N         in   asynchronous active-low reset
//   i_E             in   6809 E clock (asynchronous)
//   i_ADDRESS_BUS   in   CPU address
//   i_RW            in   1 = read, 0 = write
//   i_FLASH_SEL     in   flash window select from the address decoder
//   i_CACHE_FLUSH   in   single-cycle pulse, invalidates the cache
//   i_SPI_READY     in   controller ready (1 idle, 0 busy)
//   i_SPI_DATA      in   controller read data
//   o_SPI_CE        out  request to the controller
//   o_SPI_ADDR      out  address held for the controller
//   o_DATA          out  read data to the CPU bus
//   o_DATA_OE       out  data bus drive enable
//   o_MRDY          out  6809 MRDY (0 = stretch)
//   o_TIMEOUT       out  sticky abort flag
// ---------------------------------------------------------------------------
module flash_read_sequencer
  import flash_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit CACHE_EN       = 1'b1
) (
  input  logic        clk,
  input  logic        i_RST_N,
  input  logic        i_E,
  input  logic [15:0] i_ADDRESS_BUS,
  input  logic        i_RW,
  input  logic        i_FLASH_SEL,
  input  logic        i_CACHE_FLUSH,
  input  logic        i_SPI_READY,
  input  logic [7:0]  i_SPI_DATA,
  output logic        o_SPI_CE,
  output logic [15:0] o_SPI_ADDR,
  output logic [7:0]  o_DATA,
  output logic        o_DATA_OE,
  output logic        o_MRDY,
  output logic        o_TIMEOUT
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  logic e_level, e_rise, e_fall;

  sync_edge_detect #(
    .STAGES (SYNC_STAGES)
  ) u_e_sync (
    .clk     (clk),
    .rst_n   (i_RST_N),
    .i_async (i_E),
    .o_level (e_level),
    .o_rise  (e_rise),
    .o_fall  (e_fall)
  );

  state_e      state_q, state_d;
  logic        spi_ce_q, spi_ce_d;
  logic [15:0] spi_addr_q, spi_addr_d;
  logic [7:0]  data_q, data_d;
  logic        data_oe_q, data_oe_d;
  logic        mrdy_q, mrdy_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        cache_valid_q, cache_valid_d;
  logic [15:0] cache_addr_q, cache_addr_d;
  logic [7:0]  cache_data_q, cache_data_d;

  logic start, cache_hit, expired;

  always_comb begin
    start     = e_rise & i_FLASH_SEL & i_RW;
    // A flush arriving on the start-detect cycle must already count as a miss.
    cache_hit = CACHE_EN && cache_valid_q && !i_CACHE_FLUSH &&
                (cache_addr_q == i_ADDRESS_BUS);
    // True on the TIMEOUT_CYCLES-th cycle spent in REQ/BUSY.
    expired   = (cnt_q + 8'd1) == TIMEOUT_LIMIT;
  end

  always_comb begin
    // NOTE: every variable is given a default before the case statement so no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    spi_ce_d      = spi_ce_q;
    spi_addr_d    = spi_addr_q;
    data_d        = data_q;
    data_oe_d     = data_oe_q;
    mrdy_d        = mrdy_q;
    timeout_d     = timeout_q;
    cnt_d         = cnt_q;
    cache_valid_d = cache_valid_q;
    cache_addr_d  = cache_addr_q;
    cache_data_d  = cache_data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mrdy_d     = 1'b0;
          spi_addr_d = i_ADDRESS_BUS;
          if (cache_hit) begin
            data_d  = cache_data_q;
            state_d = DONE;
          end else begin
            spi_ce_d = 1'b1;
            cnt_d    = 8'd0;
            state_d  = REQ;
          end
        end
      end

      REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (expired) begin
          spi_ce_d  = 1'b0;
          data_d    = FLASH_BLANK_BYTE;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else if (!i_SPI_READY) begin
          spi_ce_d = 1'b0;
          state_d  = BUSY;
        end
      end

      BUSY: begin
        cnt_d = cnt_q + 8'd1;
        if (expired) begin
          data_d    = FLASH_BLANK_BYTE;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else if (i_SPI_READY) begin
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        data_d        = i_SPI_DATA;
        cache_valid_d = 1'b1;
        cache_addr_d  = spi_addr_q;
        cache_data_d  = i_SPI_DATA;
        state_d       = DONE;
      end

      DONE: begin
        mrdy_d    = 1'b1;
        data_oe_d = 1'b1;
        // The level term covers an E fall that happened while the CPU was
        // being stretched, when the fall pulse went by outside DONE.
        if (e_fall || !e_level) begin
          data_oe_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Flush overrides a same-cycle CAPTURE: the byte is still delivered but
    // the entry is left invalid.
    if (i_CACHE_FLUSH) cache_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q       <= IDLE;
      spi_ce_q      <= 1'b0;
      spi_addr_q    <= 16'h0000;
      data_q        <= FLASH_BLANK_BYTE;
      data_oe_q     <= 1'b0;
      mrdy_q        <= 1'b1;
      timeout_q     <= 1'b0;
      cnt_q         <= 8'd0;
      cache_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      spi_ce_q      <= spi_ce_d;
      spi_addr_q    <= spi_addr_d;
      data_q        <= data_d;
      data_oe_q     <= data_oe_d;
      mrdy_q        <= mrdy_d;
      timeout_q     <= timeout_d;
      cnt_q         <= cnt_d;
      cache_valid_q <= cache_valid_d;
    end
  end

  // NOTE: the cache address/data storage has no reset; it is never read
  // unless cache_valid_q is set, and only the valid bit needs a known value.
  always_ff @(posedge clk) begin
    cache_addr_q <= cache_addr_d;
    cache_data_q <= cache_data_d;
  end

  assign o_SPI_CE   = spi_ce_q;
  assign o_SPI_ADDR = spi_addr_q;
  assign o_DATA     = data_q;
  assign o_DATA_OE  = data_oe_q;
  assign o_MRDY     = mrdy_q;
  assign o_TIMEOUT  = timeout_q;

endmodule

// File: tb/tb_flash_read_sequencer.sv
// ---------------------------------------------------------------------------
// tb_flash_read_sequencer
// Two sequencer instances share the CPU bus: dut_m (default timeout) and
// dut_t (TIMEOUT_CYCLES=16). Each has its own behavioural SPI controller
// model. Bus cycles are table-driven; the multi-cycle corners (long miss,
// hit latency, flush during CAPTURE, timeout, reset mid-BUSY) are written out.
// ---------------------------------------------------------------------------
module tb_flash_read_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        e_clk;
  logic [15:0] addr_bus;
  logic        rw_bus;
  logic        sel_m, sel_t;
  logic        tb_flush, model_flush;
  logic        flush;

  logic        spi_ready_m, spi_ready_t;
  logic [7:0]  spi_data_m, spi_data_t;
  logic        ce_m, ce_t, oe_m, oe_t, mrdy_m, mrdy_t, to_m, to_t;
  logic [15:0] addr_m, addr_t;
  logic [7:0]  data_m, data_t;

  assign flush = tb_flush | model_flush;

  always #5 clk = ~clk;

  flash_read_sequencer dut_m (
    .clk           (clk),
    .i_RST_N       (rst_n),
    .i_E           (e_clk),
    .i_ADDRESS_BUS (addr_bus),
    .i_RW          (rw_bus),
    .i_FLASH_SEL   (sel_m),
    .i_CACHE_FLUSH (flush),
    .i_SPI_READY   (spi_ready_m),
    .i_SPI_DATA    (spi_data_m),
    .o_SPI_CE      (ce_m),
    .o_SPI_ADDR    (addr_m),
    .o_DATA        (data_m),
    .o_DATA_OE     (oe_m),
    .o_MRDY        (mrdy_m),
    .o_TIMEOUT     (to_m)
  );

  flash_read_sequencer #(.TIMEOUT_CYCLES(16)) dut_t (
    .clk           (clk),
    .i_RST_N       (rst_n),
    .i_E           (e_clk),
    .i_ADDRESS_BUS (addr_bus),
    .i_RW          (rw_bus),
    .i_FLASH_SEL   (sel_t),
    .i_CACHE_FLUSH (flush),
    .i_SPI_READY   (spi_ready_t),
    .i_SPI_DATA    (spi_data_t),
    .o_SPI_CE      (ce_t),
    .o_SPI_ADDR    (addr_t),
    .o_DATA        (data_t),
    .o_DATA_OE     (oe_t),
    .o_MRDY        (mrdy_t),
    .o_TIMEOUT     (to_t)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // SPI request counters (rising edges of CE).
  int   req_cnt_m = 0, req_cnt_t = 0;
  logic ce_m_prev = 1'b0, ce_t_prev = 1'b0;
  always @(negedge clk) begin
    if (ce_m && !ce_m_prev) req_cnt_m++;
    if (ce_t && !ce_t_prev) req_cnt_t++;
    ce_m_prev = ce_m;
    ce_t_prev = ce_t;
  end

  // Controller model for dut_m: ack m_ack clocks after CE is seen, stay busy
  // m_busy clocks, then return m_byte. Optionally pulse flush in CAPTURE.
  int         m_ack = 2, m_busy = 80;
  logic [7:0] m_byte = 8'h00;
  bit         m_flush_cap = 1'b0;
  initial begin
    spi_ready_m = 1'b1;
    spi_data_m  = 8'h00;
    model_flush = 1'b0;
    forever begin
      @(negedge clk);
      if (ce_m) begin
        repeat (m_ack - 1) @(negedge clk);
        spi_ready_m = 1'b0;
        repeat (m_busy) @(negedge clk);
        spi_data_m  = m_byte;
        spi_ready_m = 1'b1;
        if (m_flush_cap) begin
          @(negedge clk); model_flush = 1'b1;
          @(negedge clk); model_flush = 1'b0;
        end
      end
    end
  end

  // Controller model for dut_t: never acks while t_en is 0.
  bit         t_en = 1'b0;
  logic [7:0] t_byte = 8'h00;
  initial begin
    spi_ready_t = 1'b1;
    spi_data_t  = 8'h00;
    forever begin
      @(negedge clk);
      if (ce_t && t_en) begin
        spi_ready_t = 1'b0;
        repeat (3) @(negedge clk);
        spi_data_t  = t_byte;
        spi_ready_t = 1'b1;
      end
    end
  end

  typedef struct {
    int          reqs;
    int          ce_cyc;
    int          low_cyc;
    logic        oe_seen;
    logic [7:0]  dat;
    logic [15:0] ce_addr;
    logic        oe_held;
    logic        oe_clear;
    logic        to_flag;
    logic        hung;
  } res_t;

  // One CPU bus cycle against dut_m (tgt=0) or dut_t (tgt=1). E stays high
  // until MRDY is released (and data is driven, for a flash read), bounded.
  task automatic bus_cycle(input bit tgt, input logic [15:0] a, input logic rw,
                           input logic sel, output res_t r);
    int   r0;
    logic mr, oe, ce;
    @(negedge clk);
    addr_bus = a;
    rw_bus   = rw;
    sel_m    = sel && !tgt;
    sel_t    = sel && tgt;
    r0       = tgt ? req_cnt_t : req_cnt_m;
    r        = '{default: '0};
    r.hung   = 1'b1;
    e_clk    = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      mr = tgt ? mrdy_t : mrdy_m;
      oe = tgt ? oe_t : oe_m;
      ce = tgt ? ce_t : ce_m;
      if (ce) begin
        if (r.ce_cyc == 0) r.ce_addr = tgt ? addr_t : addr_m;
        r.ce_cyc++;
      end
      if (!mr) r.low_cyc++;
      if (oe && !r.oe_seen) begin
        r.oe_seen = 1'b1;
        r.dat     = tgt ? data_t : data_m;
      end
      if (i >= 8 && mr && (r.oe_seen || !(rw && sel))) begin
        r.hung = 1'b0;
        break;
      end
    end
    repeat (2) @(negedge clk);
    r.oe_held = tgt ? oe_t : oe_m;
    e_clk = 1'b0;
    repeat (6) @(negedge clk);
    r.oe_clear = !(tgt ? oe_t : oe_m);
    r.to_flag  = tgt ? to_t : to_m;
    r.reqs     = (tgt ? req_cnt_t : req_cnt_m) - r0;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic        sel;
    logic        flush;
    logic [7:0]  spi_byte;
    int          exp_req;
    logic        exp_oe;
    logic [7:0]  exp_data;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];
  res_t r;

  initial begin
    // Run after the 1234 -> A5 miss; one-entry cache holds 1234.
    vecs[0] = '{16'h1234, 1'b0, 1'b1, 1'b0, 8'h11, 0, 1'b0, 8'h00}; // write
    vecs[1] = '{16'h1234, 1'b1, 1'b0, 1'b0, 8'h11, 0, 1'b0, 8'h00}; // not selected
    vecs[2] = '{16'h1235, 1'b1, 1'b1, 1'b0, 8'h3C, 1, 1'b1, 8'h3C}; // new address
    vecs[3] = '{16'h1235, 1'b1, 1'b1, 1'b0, 8'h11, 0, 1'b1, 8'h3C}; // hit
    vecs[4] = '{16'h1234, 1'b1, 1'b1, 1'b0, 8'hA5, 1, 1'b1, 8'hA5}; // evicted
    vecs[5] = '{16'h1234, 1'b1, 1'b1, 1'b1, 8'h77, 1, 1'b1, 8'h77}; // flushed
    vecs[6] = '{16'h1234, 1'b1, 1'b1, 1'b0, 8'h22, 0, 1'b1, 8'h77}; // hit
    vecs[7] = '{16'hFFFF, 1'b1, 1'b1, 1'b0, 8'h00, 1, 1'b1, 8'h00};
    vecs[8] = '{16'h0000, 1'b1, 1'b1, 1'b0, 8'h81, 1, 1'b1, 8'h81};
    vecs[9] = '{16'h0000, 1'b0, 1'b1, 1'b0, 8'h11, 0, 1'b0, 8'h00}; // write

    rst_n = 1'b0; e_clk = 1'b0; addr_bus = 16'h0; rw_bus = 1'b1;
    sel_m = 1'b0; sel_t = 1'b0; tb_flush = 1'b0;
    #12;
    check("rst_ce",      ce_m,   1'b0);
    check("rst_addr",    addr_m, 16'h0000);
    check("rst_data",    data_m, 8'hFF);
    check("rst_oe",      oe_m,   1'b0);
    check("rst_mrdy",    mrdy_m, 1'b1);
    check("rst_timeout", to_m,   1'b0);
    check("rst_t_to",    to_t,   1'b0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Long miss: ack after 2 clk, busy 80 clk.
    m_ack = 2; m_busy = 80; m_byte = 8'hA5;
    bus_cycle(1'b0, 16'h1234, 1'b1, 1'b1, r);
    check("miss_hang",    r.hung,    1'b0);
    check("miss_req",     r.reqs,    1);
    check("miss_addr",    r.ce_addr, 16'h1234);
    check("miss_ce_cyc",  r.ce_cyc,  2);
    // REQ (until ack) + busy + CAPTURE + DONE, all with MRDY low.
    check("miss_mrdy_lo", r.low_cyc, 2 + 80 + 2);
    check("miss_data",    r.dat,     8'hA5);
    check("miss_oe_held", r.oe_held, 1'b1);
    check("miss_oe_clr",  r.oe_clear, 1'b1);

    // Repeat read: cache hit, MRDY released two clocks after start detect.
    m_byte = 8'hEE;
    bus_cycle(1'b0, 16'h1234, 1'b1, 1'b1, r);
    check("hit_req",     r.reqs,    0);
    check("hit_ce_cyc",  r.ce_cyc,  0);
    check("hit_mrdy_lo", r.low_cyc, 1);
    check("hit_data",    r.dat,     8'hA5);
    check("hit_oe_held", r.oe_held, 1'b1);

    m_ack = 1; m_busy = 4;
    for (int i = 0; i < NV; i++) begin
      m_byte = vecs[i].spi_byte;
      if (vecs[i].flush) begin
        @(negedge clk); tb_flush = 1'b1;
        @(negedge clk); tb_flush = 1'b0;
      end
      bus_cycle(1'b0, vecs[i].addr, vecs[i].rw, vecs[i].sel, r);
      check($sformatf("v%0d_hang", i), r.hung, 1'b0);
      check($sformatf("v%0d_req", i), r.reqs, vecs[i].exp_req);
      check($sformatf("v%0d_oe", i), r.oe_held, vecs[i].exp_oe);
      check($sformatf("v%0d_oe_clr", i), r.oe_clear, 1'b1);
      if (vecs[i].exp_oe)
        check($sformatf("v%0d_data", i), r.dat, vecs[i].exp_data);
      else
        check($sformatf("v%0d_mrdy_lo", i), r.low_cyc, 0);
    end

    // Flush coincident with CAPTURE: byte delivered, entry left invalid.
    m_byte = 8'h99; m_flush_cap = 1'b1;
    bus_cycle(1'b0, 16'h2000, 1'b1, 1'b1, r);
    m_flush_cap = 1'b0;
    check("fcap_req",  r.reqs, 1);
    check("fcap_data", r.dat,  8'h99);
    m_byte = 8'h66;
    bus_cycle(1'b0, 16'h2000, 1'b1, 1'b1, r);
    check("fcap_next_req",  r.reqs, 1);
    check("fcap_next_data", r.dat,  8'h66);

    // Timeout instance: good read, then a never-acked read.
    t_en = 1'b1; t_byte = 8'h5A;
    bus_cycle(1'b1, 16'h4000, 1'b1, 1'b1, r);
    check("t_good_req",  r.reqs,    1);
    check("t_good_data", r.dat,     8'h5A);
    check("t_good_to",   r.to_flag, 1'b0);
    t_en = 1'b0;
    bus_cycle(1'b1, 16'h4001, 1'b1, 1'b1, r);
    check("t_abort_hang",   r.hung,    1'b0);
    check("t_abort_ce_cyc", r.ce_cyc,  16);
    check("t_abort_data",   r.dat,     8'hFF);
    check("t_abort_to",     r.to_flag, 1'b1);
    t_en = 1'b1; t_byte = 8'hC3;
    bus_cycle(1'b1, 16'h4001, 1'b1, 1'b1, r);
    check("t_after_req",  r.reqs,    1);
    check("t_after_data", r.dat,     8'hC3);
    check("t_after_to",   r.to_flag, 1'b1);
    bus_cycle(1'b1, 16'h4001, 1'b1, 1'b1, r);
    check("t_hit_req",  r.reqs,    0);
    check("t_hit_data", r.dat,     8'hC3);
    check("t_hit_to",   r.to_flag, 1'b1);

    // Reset while dut_m sits in BUSY.
    m_ack = 2; m_busy = 80; m_byte = 8'h5C;
    @(negedge clk);
    addr_bus = 16'h5555; rw_bus = 1'b1; sel_m = 1'b1; sel_t = 1'b0; e_clk = 1'b1;
    repeat (10) @(negedge clk);
    check("busy_pre_mrdy", mrdy_m, 1'b0);
    check("busy_pre_data", data_m, 8'h66);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ce",   ce_m,   1'b0);
    check("arst_mrdy", mrdy_m, 1'b1);
    check("arst_oe",   oe_m,   1'b0);
    check("arst_data", data_m, 8'hFF);
    check("arst_addr", addr_m, 16'h0000);
    check("arst_t_to", to_t,   1'b0);
    @(negedge clk); e_clk = 1'b0; sel_m = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_oe",   oe_m,   1'b0);
    check("post_rst_mrdy", mrdy_m, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
